// File: rtl/mem_unit.sv
// rtl/mem_unit.sv - single-access load/store unit with wait timeout; MEM_UNIT_MISALIGN_TRAP_EN traps misaligned halfword/word accesses
module mem_unit #(
    parameter int ADDR_W  = 30,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        read_op,
    input  logic [1:0]        write_op,
    input  logic [31:0]       addr_in,
    input  logic [31:0]       wdata_in,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       rdata_out,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    localparam logic [2:0] LB    = 3'b000;
    localparam logic [2:0] LH    = 3'b001;
    localparam logic [2:0] LNONE = 3'b011;
    localparam logic [2:0] LBU   = 3'b100;
    localparam logic [2:0] LHU   = 3'b101;
    localparam logic [1:0] SB    = 2'b00;
    localparam logic [1:0] SH    = 2'b01;
    localparam logic [1:0] SNONE = 2'b11;

    // Last wait count before abort: TIMEOUT ACCESS cycles without mem_ready at most.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_FIN
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  rop_q;
    logic [1:0]  wop_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [15:0] cnt_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic        req_illegal;
    logic        req_noop;
    logic        req_misalign;
    logic        fin_en;
    logic        fin_err;
    logic        load_en;
    logic        access;
    logic        is_byte;
    logic        is_half;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val;

    always_comb begin
        req_illegal  = (read_op[2:1] == 2'b11) || (read_op != LNONE && write_op != SNONE);
        req_noop     = (read_op == LNONE) && (write_op == SNONE);
        req_misalign = 1'b0;
`ifdef MEM_UNIT_MISALIGN_TRAP_EN
        if (read_op == LH || read_op == LHU || write_op == SH) begin
            req_misalign = addr_in[0];
        end else if (read_op == 3'b010 || write_op == 2'b10) begin
            req_misalign = (addr_in[1:0] != 2'b00);
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        fin_en  = 1'b0;
        fin_err = 1'b0;
        load_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (req_illegal || req_misalign) begin
                        state_d = S_FIN;
                        fin_en  = 1'b1;
                        fin_err = 1'b1;
                    end else if (req_noop) begin
                        state_d = S_FIN;
                        fin_en  = 1'b1;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                // A ready arriving on the final allowed cycle still completes normally.
                if (mem_ready) begin
                    state_d = S_FIN;
                    fin_en  = 1'b1;
                    load_en = (rop_q != LNONE);
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_FIN;
                    fin_en  = 1'b1;
                    fin_err = 1'b1;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rop_q   <= LNONE;
            wop_q   <= SNONE;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (state_q == S_IDLE && start) begin
                rop_q   <= read_op;
                wop_q   <= write_op;
                addr_q  <= addr_in;
                wdata_q <= wdata_in;
            end
            if (state_q != S_ACCESS) begin
                cnt_q <= '0;
            end else if (!mem_ready) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (fin_en) begin
                err_q   <= fin_err;
                rdata_q <= load_en ? load_val : '0;
            end
        end
    end

    always_comb begin
        ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (rop_q)
            LB:      load_val = {{24{ld_byte[7]}}, ld_byte};
            LBU:     load_val = {24'd0, ld_byte};
            LH:      load_val = {{16{ld_half[15]}}, ld_half};
            LHU:     load_val = {16'd0, ld_half};
            default: load_val = mem_rdata;
        endcase
    end

    // Only one of the latched ops is active once a request reaches ACCESS.
    always_comb begin
        is_byte = (rop_q == LB) || (rop_q == LBU) || (wop_q == SB);
        is_half = (rop_q == LH) || (rop_q == LHU) || (wop_q == SH);
        mem_be  = 4'b0000;
        if (access) begin
            if (is_byte) begin
                mem_be = 4'b0001 << addr_q[1:0];
            end else if (is_half) begin
                mem_be = addr_q[1] ? 4'b1100 : 4'b0011;
            end else begin
                mem_be = 4'b1111;
            end
        end
    end

    always_comb begin
        mem_wdata = '0;
        if (mem_we) begin
            case (wop_q)
                SB:      mem_wdata = {4{wdata_q[7:0]}};
                SH:      mem_wdata = {2{wdata_q[15:0]}};
                default: mem_wdata = wdata_q;
            endcase
        end
    end

    assign access    = (state_q == S_ACCESS);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FIN);
    assign error     = done & err_q;
    assign rdata_out = rdata_q;
    assign mem_re    = access && (rop_q != LNONE);
    assign mem_we    = access && (wop_q != SNONE);
    assign mem_addr  = access ? addr_q[ADDR_W+1:2] : '0;

endmodule

// File: tb/tb_mem_unit.sv
// tb/tb_mem_unit.sv - directed and random checks of mem_unit against a byte-lane reference model
module tb_mem_unit;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  read_op;
    logic [1:0]  write_op;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] rdata_out;
    logic        mem_re;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;

    mem_unit #(.ADDR_W(30), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .read_op(read_op), .write_op(write_op),
        .addr_in(addr_in), .wdata_in(wdata_in), .busy(busy), .done(done), .error(error),
        .rdata_out(rdata_out), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One request from start strobe to return to IDLE, with memory answering after 'waits' stall cycles.
    task automatic run_op(input logic [2:0] rop, input logic [1:0] wop, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] md, input int waits);
        int          nbytes, base, cyc, acc, exp_acc, exp_lat;
        bit          illegal, noop, misal, to_err, exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_rd;
        longint      v;

        illegal = (rop >= 3'd6) || (rop != 3'd3 && wop != 2'd3);
        noop    = (rop == 3'd3) && (wop == 2'd3);
        nbytes  = (rop == 3'd2 || wop == 2'd2) ? 4 :
                  (rop == 3'd1 || rop == 3'd5 || wop == 2'd1) ? 2 : 1;
`ifdef MEM_UNIT_MISALIGN_TRAP_EN
        misal = !illegal && !noop && ((a % nbytes) != 0);
`else
        misal = 1'b0;
`endif
        base   = int'(a[1:0]) & ~(nbytes - 1);
        exp_be = 4'(((1 << nbytes) - 1) << base);
        for (int i = 0; i < 4; i++) begin
            exp_wd[8*i +: 8] = wd[8*(i % nbytes) +: 8];
        end
        v = (longint'(md) >> (8 * base)) & ((64'd1 << (8 * nbytes)) - 1);
        if ((rop == 3'd0 || rop == 3'd1) && v[8*nbytes-1]) begin
            v = v - (64'd1 << (8 * nbytes));
        end

        if (illegal || noop || misal) begin
            exp_acc = 0;
            exp_lat = 1;
            exp_err = illegal || misal;
            exp_rd  = '0;
        end else begin
            to_err  = (waits >= TO);
            exp_acc = to_err ? TO : waits + 1;
            exp_lat = exp_acc + 1;
            exp_err = to_err;
            exp_rd  = (!to_err && rop != 3'd3) ? 32'(v) : 32'd0;
        end

        @(negedge clk);
        read_op   = rop;
        write_op  = wop;
        addr_in   = a;
        wdata_in  = wd;
        mem_rdata = md;
        mem_ready = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        acc   = 0;
        while (!done && cyc < 40) begin
            if (mem_re || mem_we) begin
                acc++;
                check("re", 32'(mem_re), 32'(rop != 3'd3));
                check("we", 32'(mem_we), 32'(wop != 2'd3));
                check("be", 32'(mem_be), 32'(exp_be));
                check("addr", 32'(mem_addr), a >> 2);
                if (wop != 2'd3) check("wdata", mem_wdata, exp_wd);
            end
            mem_ready = (mem_re || mem_we) && (acc == waits + 1);
            start     = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
        end
        mem_ready = 1'b0;
        start     = 1'b0;
        check("done_seen", 32'(done), 32'd1);
        check("latency", 32'(cyc), 32'(exp_lat));
        check("access_cycles", 32'(acc), 32'(exp_acc));
        check("error", 32'(error), 32'(exp_err));
        check("rdata", rdata_out, exp_rd);
        check("fin_strobes", {30'd0, mem_re, mem_we}, 32'd0);
        @(negedge clk);
        check("idle_busy", {30'd0, busy, done}, 32'd0);
        check("idle_be", 32'(mem_be), 32'd0);
        check("rdata_hold", rdata_out, exp_rd);
    endtask

    initial begin
        logic [2:0] rop;
        logic [1:0] wop;

        reset     = 1'b1;
        start     = 1'b0;
        read_op   = 3'd3;
        write_op  = 2'd3;
        addr_in   = '0;
        wdata_in  = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        #3;
        check("rst_flags", {26'd0, busy, done, error, mem_re, mem_we, 1'b0}, 32'd0);
        check("rst_rdata", rdata_out, 32'd0);
        check("rst_be", 32'(mem_be), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(3'd0, 2'd3, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 0);
        check("lb_const", rdata_out, 32'hFFFF_FF80);
        run_op(3'd3, 2'd1, 32'h0000_0202, 32'h0000_BEEF, 32'h0, 3);
        run_op(3'd2, 2'd3, 32'h0000_0400, 32'h0, 32'h1111_2222, 10);
        check("timeout_rdata", rdata_out, 32'd0);
        run_op(3'd2, 2'd3, 32'h0000_0404, 32'h0, 32'h1234_5678, TO - 1);
        run_op(3'd5, 2'd3, 32'h0000_0101, 32'h0, 32'hA5A5_8001, 0);
        run_op(3'd2, 2'd2, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0);
        run_op(3'd3, 2'd3, 32'h0000_0020, 32'h0, 32'h0, 0);
        run_op(3'd6, 2'd3, 32'h0000_0030, 32'h0, 32'h0, 0);
        run_op(3'd3, 2'd0, 32'h0000_0031, 32'h0000_00A7, 32'h0, 1);
        run_op(3'd1, 2'd3, 32'h0000_0042, 32'h0, 32'h9234_0000, 2);

        for (int n = 0; n < 60; n++) begin
            rop = 3'($urandom_range(0, 7));
            wop = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    rop = 3'($urandom_range(0, 5));
                    wop = 2'd3;
                end else begin
                    rop = 3'd3;
                    wop = 2'($urandom_range(0, 2));
                end
            end
            run_op(rop, wop, $urandom, $urandom, $urandom, $urandom_range(0, 5));
        end

        @(negedge clk);
        read_op  = 3'd2;
        write_op = 2'd3;
        addr_in  = 32'h0000_0800;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("pre_reset_re", 32'(mem_re), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_re", 32'(mem_re), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_be", 32'(mem_be), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("no_done_after_reset", {30'd0, busy, done}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_unit.md
MEM_UNIT -- requirements
Module: mem_unit

Interface
REQ-001 Parameter ADDR_W, default 30, width of the word address driven to memory (byte address bits [ADDR_W+1:2]).
REQ-002 Parameter TIMEOUT, default 255, maximum cycles in ACCESS without mem_ready before abort; legal range 1..65535.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; asserting it forces reset state immediately, independent of clk.
REQ-005 start  in  1  request strobe, sampled only in IDLE.
REQ-006 read_op  in  3  load op: LB=000 LH=001 LW=010 LNONE=011 LBU=100 LHU=101; 110/111 illegal.
REQ-007 write_op  in  2  store op: SB=00 SH=01 SW=10 SNONE=11.
REQ-008 addr_in  in  32  byte address.  wdata_in  in  32  store data, low bits significant.
REQ-009 busy  out  1  high in every non-IDLE state.
REQ-010 done  out  1  one-cycle completion pulse.  error  out  1  valid with done.
REQ-011 rdata_out  out  32  extended load result, held until next done.
REQ-012 mem_re  out  1;  mem_we  out  1;  mem_addr  out  ADDR_W;  mem_wdata  out  32;  mem_be  out  4.
REQ-013 mem_rdata  in  32;  mem_ready  in  1  memory accepts/completes the current access this cycle.

Function
REQ-014 States SHALL be IDLE, ACCESS, FIN; IDLE with start low stays IDLE.
REQ-015 IDLE+start: latch ops, addr_in, wdata_in; if request illegal (read_op 110/111, or read_op!=LNONE and write_op!=SNONE) or (macro on) misaligned -> FIN with error=1; if read_op=LNONE and write_op=SNONE -> FIN with error=0; else -> ACCESS.
REQ-016 In ACCESS, mem_re=(read_op!=LNONE), mem_we=(write_op!=SNONE), mem_addr=latched addr[ADDR_W+1:2]; all memory outputs stable until mem_ready; both strobes 0 in IDLE and FIN.
REQ-017 mem_be: byte ops 4'b0001<<addr[1:0]; halfword ops addr[1]?1100:0011; word ops 1111; 0000 outside ACCESS.
REQ-018 mem_wdata: SB byte replicated to all four lanes; SH halfword replicated to both halves; SW unchanged.
REQ-019 ACCESS+mem_ready: register load result into rdata_out, -> FIN, error=0; latency start-to-done = 2 + wait cycles (zero-wait: done two cycles after start).
REQ-020 Load extraction: byte lane addr[1:0] / halfword lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged; stores leave rdata_out = 0.
REQ-021 Wait counter SHALL clear on ACCESS entry, increment each ACCESS cycle without mem_ready; on reaching TIMEOUT -> FIN, error=1, rdata_out=0, strobes drop next cycle.
REQ-022 mem_ready in the same cycle the counter reaches TIMEOUT SHALL win: normal completion, error=0.
REQ-023 FIN asserts done for exactly one cycle, then -> IDLE; start during ACCESS/FIN is ignored, not queued.
REQ-024 Error completions SHALL not alter memory (no mem_we pulse) and SHALL set rdata_out=0.

Reset
REQ-025 Reset: state IDLE, counter 0, busy=0, done=0, error=0, rdata_out=0, mem_re=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
REQ-026 Reset during ACCESS SHALL abandon the access with strobes low immediately; no done pulse for it after release.

Configuration
REQ-027 Macro MEM_UNIT_MISALIGN_TRAP_EN: defined -> halfword with addr[0]=1 or word with addr[1:0]!=0 completes via FIN with error=1 and no bus access.
REQ-028 Macro undefined -> no misalignment check; halfword ignores addr[0], word ignores addr[1:0]; access proceeds normally.

Verification
REQ-029 LB addr=0x103, mem_rdata=0x80FF_FFFF, ready immediately -> done at cycle 2, rdata_out=0xFFFF_FF80, error=0.
REQ-030 SH addr=0x202 wdata=0x0000_BEEF, ready after 3 waits -> mem_we held 4 cycles, mem_be=1100, mem_wdata=0xBEEF_BEEF, mem_addr=0x80.
REQ-031 LW, mem_ready never, TIMEOUT=4 -> done with error=1, rdata_out=0, mem_re low after abort.
REQ-032 LHU addr=0x101 -> macro on: done+error=1, no mem_re; macro off: mem_be=0011, rdata_out zero-extended low half.
REQ-033 read_op=LW with write_op=SW -> done+error=1, no strobes; read_op=LNONE, write_op=SNONE -> done, error=0.
REQ-034 reset asserted mid-ACCESS with mem_re=1 -> mem_re=0 same cycle, busy=0, no done after release.
